// File: rtl/mdu_iterativo_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM states and default sizing.
package mdu_iterativo_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    OP_MULU  = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_iterativo_step.sv
// One iteration of the MDU datapath: a shift-add multiply step or a restoring
// divide step over the {hi, lo} accumulator pair. Purely combinational.
module mdu_step
  import mdu_iterativo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;

  // Multiply: conditionally add the multiplicand into the upper half, keeping the carry.
  assign mul_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});

  // Divide: the (WIDTH+1)-bit shifted remainder is always below twice the divisor,
  // so a successful trial subtraction always fits back into WIDTH bits.
  assign rem_sh    = {hi_i, lo_i[WIDTH-1]};
  assign no_borrow = rem_sh >= {1'b0, opnd_i};
  assign rem_next  = no_borrow ? (rem_sh[WIDTH-1:0] - opnd_i) : rem_sh[WIDTH-1:0];

  assign hi_o = is_div_i ? rem_next : mul_sum[WIDTH:1];
  assign lo_o = is_div_i ? {lo_i[WIDTH-2:0], no_borrow} : {mul_sum[0], lo_i[WIDTH-1:1]};

endmodule

// File: rtl/mdu_iterativo.sv
// Iterative unsigned multiply/divide unit feeding the register file write port.
// One bit per clock, then a single-cycle write-back beat.
module mdu_iterativo
  import mdu_iterativo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] rd,
  output logic              busy,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic              div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e            state_q;
  op_e               op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [WIDTH-1:0]  opnd_q;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              wb_en_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [WIDTH-1:0]  wb_data_q;
  logic              div_zero_q;

  logic [WIDTH-1:0]  step_hi;
  logic [WIDTH-1:0]  step_lo;
  logic [WIDTH-1:0]  result_d;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_q[1]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // After the last step, hi holds the product high word / remainder and lo holds
  // the product low word / quotient.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result_d = step_lo;
    case (op_q)
      OP_MULHU, OP_REMU: result_d = step_hi;
      default:           result_d = step_lo;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_MULU;
      rd_q       <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= op_e'(op);
            rd_q   <= rd;
            opnd_q <= op[1] ? b : a;
            hi_q   <= '0;
            lo_q   <= op[1] ? a : b;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (op[1] && (b == '0)) begin
              // Divide by zero skips iteration: quotient all ones, remainder = dividend.
              state_q    <= S_DONE;
              wb_en_q    <= 1'b1;
              wb_addr_q  <= rd;
              wb_data_q  <= op[0] ? a : '1;
              div_zero_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q    <= S_DONE;
            wb_en_q    <= 1'b1;
            wb_addr_q  <= rd_q;
            wb_data_q  <= result_d;
            div_zero_q <= 1'b0;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          wb_en_q    <= 1'b0;
          div_zero_q <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          wb_en_q    <= 1'b0;
          div_zero_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign wb_en    = wb_en_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mdu_iterativo.sv
// Self-checking bench for mdu_iterativo: a behavioural model predicts every
// write-back beat and the busy window; directed cases pin literal results.
module tb_mdu_iterativo;
  import mdu_iterativo_pkg::*;

  localparam int W  = 32;
  localparam int AW = 5;

  typedef struct {
    int           due;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          dz;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [AW-1:0] rd = '0;
  logic          busy;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          div_zero;

  int n_checks = 0;
  int n_err    = 0;

  int   cyc = 0;
  int   busy_until = -1;
  bit   armed = 1'b0;
  exp_t exp_q[$];
  logic exp_en;

  int            wb_cnt = 0;
  int            last_wb_cyc = 0;
  logic [W-1:0]  last_data;
  logic [AW-1:0] last_addr;
  logic          last_dz;
  int            acc_cyc;
  int            lat;

  mdu_iterativo #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .rd       (rd),
    .busy     (busy),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands, plus the write-back cycle.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [AW-1:0] r, input int k);
    exp_t         e;
    logic [63:0]  p;
    p      = {32'b0, x} * {32'b0, y};
    e.addr = r;
    e.dz   = 1'b0;
    e.due  = k + W;
    case (o)
      2'b00:   e.data = p[31:0];
      2'b01:   e.data = p[63:32];
      2'b10:   e.data = (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: e.data = (y == 0) ? x : x % y;
    endcase
    if (o[1] && y == 0) begin
      e.dz  = 1'b1;
      e.due = k;
    end
    return e;
  endfunction

  // Compare process: outputs are checked on the falling edge of every cycle.
  always @(negedge clk) begin
    if (armed) begin
      exp_en = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("busy", busy, (cyc <= busy_until));
      check("wb_en", wb_en, exp_en);
      if (exp_en) begin
        check("wb_addr", wb_addr, exp_q[0].addr);
        check("wb_data", wb_data, exp_q[0].data);
        check("div_zero", div_zero, exp_q[0].dz);
        void'(exp_q.pop_front());
      end else begin
        check("div_zero_quiet", div_zero, 1'b0);
      end
      if (wb_en) begin
        wb_cnt++;
        last_wb_cyc = cyc;
        last_data   = wb_data;
        last_addr   = wb_addr;
        last_dz     = div_zero;
      end
      if (rst) begin
        exp_q.delete();
        busy_until = -1;
      end else if (start && cyc > busy_until) begin
        exp_q.push_back(model(op, a, b, rd, cyc + 1));
        busy_until = exp_q[$].due;
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [AW-1:0] r);
    int c0;
    int n;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; rd = r;
    @(posedge clk); #1;
    start   = 1'b0;
    acc_cyc = cyc;
    c0      = wb_cnt;
    check("busy_after_accept", busy, 1'b1);
    n = 0;
    while (wb_cnt == c0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    check("wb_pulse_seen", wb_cnt - c0, 1);
    #1;
    check("busy_released", busy, 1'b0);
    lat = last_wb_cyc - acc_cyc;
  endtask

  initial begin
    int k;
    int c0;
    int offs[3];
    offs[0] = 5; offs[1] = 31; offs[2] = 32;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_wb_en", wb_en, 1'b0);
    check("reset_wb_addr", wb_addr, 0);
    check("reset_wb_data", wb_data, 0);
    check("reset_div_zero", div_zero, 1'b0);
    rst   = 1'b0;
    armed = 1'b1;

    run_op(OP_MULU, 7, 6, 3);
    check("mulu_7x6", last_data, 42);
    check("mulu_addr", last_addr, 3);
    check("mulu_latency", lat, 32);

    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4);
    check("mulhu_max", last_data, 32'hFFFF_FFFE);
    run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    check("mulu_max", last_data, 32'h0000_0001);

    run_op(OP_DIVU, 100, 7, 6);
    check("divu_100_7", last_data, 14);
    check("divu_dz", last_dz, 1'b0);
    run_op(OP_REMU, 100, 7, 7);
    check("remu_100_7", last_data, 2);
    run_op(OP_DIVU, 5, 9, 8);
    check("divu_5_9", last_data, 0);
    run_op(OP_REMU, 5, 9, 0);
    check("remu_5_9", last_data, 5);
    check("remu_rd0", last_addr, 0);

    run_op(OP_DIVU, 32'h1234, 0, 10);
    check("divz_quot", last_data, 32'hFFFF_FFFF);
    check("divz_flag", last_dz, 1'b1);
    check("divz_latency", lat, 0);
    run_op(OP_REMU, 32'h1234, 0, 11);
    check("remz_rem", last_data, 32'h1234);
    check("remz_flag", last_dz, 1'b1);

    // Restarts while busy and operand changes after acceptance must not disturb the result.
    @(posedge clk); #1;
    start = 1'b1; op = OP_MULU; a = 1000; b = 3; rd = 9;
    @(posedge clk); #1;
    start = 1'b0; k = cyc; c0 = wb_cnt;
    a = 32'hDEAD_BEEF; b = 32'h1357_9BDF; rd = 17;
    foreach (offs[i]) begin
      wait_cyc(k + offs[i]);
      start = 1'b1; op = OP_MULHU; a = 55; b = 66; rd = 20;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1;
    check("restart_one_pulse", wb_cnt - c0, 1);
    check("restart_data", last_data, 3000);
    check("restart_addr", last_addr, 9);
    check("restart_latency", last_wb_cyc - k, 32);

    // Reset in the middle of a divide aborts it silently.
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; a = 32'h8000_0000; b = 3; rd = 12;
    @(posedge clk); #1;
    start = 1'b0; k = cyc; c0 = wb_cnt;
    wait_cyc(k + 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_wb_en", wb_en, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_wb", wb_cnt - c0, 0);
    run_op(OP_MULU, 3, 4, 13);
    check("after_abort_mulu", last_data, 12);
    check("after_abort_latency", lat, 32);

    // Random traffic: the model decides acceptance, results and timing.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      rd    = AW'($urandom);
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
